// File: rtl/led_blink_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_blink_pkg
// Description : Shared types and constants for the LED blink controller.
// Revision    : 1.0 - initial release
// ============================================================================
package led_blink_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  // State encodings match mode_e so an accepted mode maps straight onto a state.
  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_ON    = 2'd1,
    S_BLINK = 2'd2,
    S_BURST = 2'd3
  } state_e;

  localparam int unsigned C_DEFAULT_HALF_PERIOD = 25_000_000;

endpackage : led_blink_pkg
`default_nettype wire

// File: rtl/led_blink_controller_tick_counter.sv
`default_nettype none
// ============================================================================
// Module      : tick_counter
// Description : Programmable terminal-count counter producing a one-cycle
//               combinational terminal-count strobe while enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_counter
  import led_blink_pkg::*;
#(
  parameter int CNT_WIDTH = 26
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] terminal,
  output logic                 tc_pulse
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  always_comb begin
    count_d  = count_q;
    tc_pulse = enable && (count_q == terminal);
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = tc_pulse ? '0 : count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : tick_counter
`default_nettype wire

// File: rtl/led_blink_controller.sv
`default_nettype none
// ============================================================================
// Module      : led_blink_controller
// Description : Mode/rate configurable LED blinker (OFF/ON/BLINK/BURST) with
//               a valid/ready configuration port and clock-enable tick.
// Revision    : 1.0 - initial release
// ============================================================================
module led_blink_controller
  import led_blink_pkg::*;
#(
  parameter int          CNT_WIDTH           = 26,
  parameter int unsigned DEFAULT_HALF_PERIOD = C_DEFAULT_HALF_PERIOD,
  parameter int          BURST_WIDTH         = 4
) (
  input  logic                   clk_in,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [1:0]             cfg_mode,
  input  logic [CNT_WIDTH-1:0]   cfg_half_period,
  input  logic [BURST_WIDTH-1:0] cfg_burst_cnt,
  output logic                   led_out,
  output logic                   tick,
  output logic                   busy,
  output logic                   done
);

  state_e                 state_q, state_d;
  logic                   led_q, led_d;
  logic                   tick_q, tick_d;
  logic                   done_q, done_d;
  logic [CNT_WIDTH-1:0]   half_period_q, half_period_d;
  logic [BURST_WIDTH-1:0] burst_rem_q, burst_rem_d;

  logic                   accept;
  logic                   counting;
  logic                   cnt_clear;
  logic                   cnt_enable;
  logic                   tc;
  logic [CNT_WIDTH-1:0]   terminal;

  assign cfg_ready  = (state_q != S_BURST);
  assign busy       = (state_q == S_BURST);
  assign accept     = cfg_valid && cfg_ready;
  assign counting   = (state_q == S_BLINK) || (state_q == S_BURST);
  // A new configuration restarts the phase instead of letting a coincident
  // terminal count toggle the LED.
  assign cnt_clear  = accept || !counting;
  assign cnt_enable = counting && !accept;
  assign terminal   = half_period_q - CNT_WIDTH'(1);

  tick_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_tick_counter (
    .clk_in   (clk_in),
    .rst      (rst),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .terminal (terminal),
    .tc_pulse (tc)
  );

  always_comb begin
    state_d       = state_q;
    led_d         = led_q;
    tick_d        = 1'b0;
    done_d        = 1'b0;
    half_period_d = half_period_q;
    burst_rem_d   = burst_rem_q;

    if (accept) begin
      half_period_d = (cfg_half_period == '0) ? CNT_WIDTH'(1) : cfg_half_period;
      state_d       = state_e'(cfg_mode);
      led_d         = (cfg_mode != MODE_OFF);
      burst_rem_d   = cfg_burst_cnt;
      if ((cfg_mode == MODE_BURST) && (cfg_burst_cnt == '0)) begin
        state_d = S_OFF;
        led_d   = 1'b0;
        done_d  = 1'b1;
      end
    end else if (tc) begin
      led_d  = ~led_q;
      tick_d = 1'b1;
      // A burst is counted on each falling LED transition.
      if ((state_q == S_BURST) && led_q) begin
        burst_rem_d = burst_rem_q - BURST_WIDTH'(1);
        if (burst_rem_q == BURST_WIDTH'(1)) begin
          state_d = S_OFF;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state_q       <= S_OFF;
      led_q         <= 1'b0;
      tick_q        <= 1'b0;
      done_q        <= 1'b0;
      half_period_q <= CNT_WIDTH'(DEFAULT_HALF_PERIOD);
      burst_rem_q   <= '0;
    end else begin
      state_q       <= state_d;
      led_q         <= led_d;
      tick_q        <= tick_d;
      done_q        <= done_d;
      half_period_q <= half_period_d;
      burst_rem_q   <= burst_rem_d;
    end
  end

  assign led_out = led_q;
  assign tick    = tick_q;
  assign done    = done_q;

endmodule : led_blink_controller
`default_nettype wire

// File: tb/tb_led_blink_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_blink_controller
// Description : Directed self-checking bench for led_blink_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_blink_controller;

  localparam int CNT_WIDTH   = 26;
  localparam int BURST_WIDTH = 4;

  logic                   clk_in;
  logic                   rst;
  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [1:0]             cfg_mode;
  logic [CNT_WIDTH-1:0]   cfg_half_period;
  logic [BURST_WIDTH-1:0] cfg_burst_cnt;
  logic                   led_out;
  logic                   tick;
  logic                   busy;
  logic                   done;

  int checks   = 0;
  int failures = 0;

  led_blink_controller #(
    .CNT_WIDTH   (CNT_WIDTH),
    .BURST_WIDTH (BURST_WIDTH)
  ) dut (
    .clk_in          (clk_in),
    .rst             (rst),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_mode        (cfg_mode),
    .cfg_half_period (cfg_half_period),
    .cfg_burst_cnt   (cfg_burst_cnt),
    .led_out         (led_out),
    .tick            (tick),
    .busy            (busy),
    .done            (done)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_cfg(input logic [1:0] mode, input int hp, input int n);
    cfg_valid       = 1'b1;
    cfg_mode        = mode;
    cfg_half_period = CNT_WIDTH'(hp);
    cfg_burst_cnt   = BURST_WIDTH'(n);
  endtask

  // Expected outputs after edges 0..8 of BLINK hp=3
  logic [8:0] blink_led  = 9'b1_1100_0111; // bit e = led after edge e
  logic [8:0] blink_tick = 9'b0_0100_1000;
  // BURST hp=2 N=2 after edges 0..6
  logic [6:0] burst_led  = 7'b011_0011;
  logic [6:0] burst_tick = 7'b101_0100;

  initial begin
    rst             = 1'b0;
    cfg_valid       = 1'b0;
    cfg_mode        = 2'd0;
    cfg_half_period = '0;
    cfg_burst_cnt   = '0;

    // Reset
    repeat (3) step();
    rst = 1'b1;
    check_eq("rst_led",   led_out,   0);
    check_eq("rst_tick",  tick,      0);
    check_eq("rst_ready", cfg_ready, 1);
    check_eq("rst_busy",  busy,      0);
    check_eq("rst_done",  done,      0);
    step();
    check_eq("idle_led",  led_out,   0);

    // BLINK hp=3, handshake at edge 0
    drive_cfg(2'd2, 3, 0);
    step();
    cfg_valid = 1'b0;
    check_eq("blink_led_e0",  led_out, blink_led[0]);
    check_eq("blink_tick_e0", tick,    blink_tick[0]);
    for (int e = 1; e < 9; e++) begin
      step();
      check_eq($sformatf("blink_led_e%0d", e),  led_out, blink_led[e]);
      check_eq($sformatf("blink_tick_e%0d", e), tick,    blink_tick[e]);
    end

    // Handshake on the terminal-count edge (edge 9): config wins, counter restarts
    drive_cfg(2'd2, 2, 0);
    step();
    cfg_valid = 1'b0;
    check_eq("hs_tc_led",   led_out, 1);
    check_eq("hs_tc_tick",  tick,    0);
    step();
    check_eq("hs_tc_led1",  led_out, 1);
    check_eq("hs_tc_tick1", tick,    0);
    step();
    check_eq("hs_tc_led2",  led_out, 0);
    check_eq("hs_tc_tick2", tick,    1);

    // BLINK with half period 0 behaves as 1
    drive_cfg(2'd2, 0, 0);
    step();
    cfg_valid = 1'b0;
    check_eq("hp0_led0", led_out, 1);
    for (int e = 1; e < 5; e++) begin
      step();
      check_eq($sformatf("hp0_led%0d", e),  led_out, (e % 2 == 0) ? 1 : 0);
      check_eq($sformatf("hp0_tick%0d", e), tick,    1);
    end

    // ON mode: steady on
    drive_cfg(2'd1, 5, 0);
    step();
    cfg_valid = 1'b0;
    for (int e = 0; e < 4; e++) begin
      check_eq("on_led",  led_out, 1);
      check_eq("on_tick", tick,    0);
      step();
    end

    // OFF mode
    drive_cfg(2'd0, 5, 0);
    step();
    cfg_valid = 1'b0;
    check_eq("off_led", led_out, 0);

    // BURST hp=2 N=2, with an ON request held throughout
    drive_cfg(2'd3, 2, 2);
    step();
    drive_cfg(2'd1, 7, 0);
    for (int e = 0; e < 7; e++) begin
      if (e > 0) step();
      check_eq($sformatf("burst_led_e%0d", e),  led_out, burst_led[e]);
      check_eq($sformatf("burst_tick_e%0d", e), tick,    burst_tick[e]);
      check_eq($sformatf("burst_done_e%0d", e), done,    (e == 6) ? 1 : 0);
      check_eq($sformatf("burst_busy_e%0d", e), busy,    (e < 6) ? 1 : 0);
      check_eq($sformatf("burst_rdy_e%0d", e),  cfg_ready, (e < 6) ? 0 : 1);
    end
    // Held request accepted on the edge right after done
    step();
    cfg_valid = 1'b0;
    check_eq("held_led",  led_out, 1);
    check_eq("held_done", done,    0);
    check_eq("held_busy", busy,    0);
    check_eq("held_tick", tick,    0);

    // BURST with N=0 completes immediately
    drive_cfg(2'd3, 4, 0);
    step();
    cfg_valid = 1'b0;
    check_eq("n0_done",  done,      1);
    check_eq("n0_led",   led_out,   0);
    check_eq("n0_ready", cfg_ready, 1);
    check_eq("n0_busy",  busy,      0);
    step();
    check_eq("n0_done1", done,      0);
    check_eq("n0_led1",  led_out,   0);

    // Reset mid-burst aborts with no done pulse
    drive_cfg(2'd3, 2, 3);
    step();
    cfg_valid = 1'b0;
    repeat (3) step();
    check_eq("mid_busy", busy, 1);
    rst = 1'b0;
    step();
    check_eq("mrst_led",   led_out,   0);
    check_eq("mrst_tick",  tick,      0);
    check_eq("mrst_done",  done,      0);
    check_eq("mrst_busy",  busy,      0);
    check_eq("mrst_ready", cfg_ready, 1);
    rst = 1'b1;
    for (int e = 0; e < 10; e++) begin
      step();
      check_eq("post_rst_done", done,    0);
      check_eq("post_rst_led",  led_out, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_led_blink_controller
`default_nettype wire

// File: doc/led_blink_controller.md
Name: led_blink_controller

Overview:
- Sequences a programmable-rate LED blinker: accepts mode/rate configuration over a valid/ready handshake and drives one LED output.
- Internal terminal-count counter generates a one-cycle `tick` enable (clock-enable style, no derived clocks).
- Sits between board-level control logic (buttons/CSR) and LED pins; replaces free-running fixed-rate dividers.

Parameters:
- CNT_WIDTH, 26, width of half-period counter and cfg_half_period.
- DEFAULT_HALF_PERIOD, 25_000_000, half period in clk_in cycles after reset (0.5 s at 50 MHz).
- BURST_WIDTH, 4, width of burst blink count.

Ports:
- clk_in  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous, active-low reset; sampled on clk_in rising edge.
- cfg_valid  input  1  configuration request.
- cfg_ready  output  1  controller can accept configuration.
- cfg_mode  input  2  0=OFF, 1=ON, 2=BLINK, 3=BURST.
- cfg_half_period  input  CNT_WIDTH  cycles per LED phase; 0 treated as 1.
- cfg_burst_cnt  input  BURST_WIDTH  number of on-phases in BURST.
- led_out  output  1  LED drive, registered.
- tick  output  1  one-cycle pulse on every LED toggle, registered.
- busy  output  1  high while a burst is running.
- done  output  1  one-cycle pulse when a burst completes.

Behaviour:
- Reset (rst==0 at edge):
  - state=S_OFF, counter=0, half_period=DEFAULT_HALF_PERIOD, burst_rem=0.
  - led_out=0, tick=0, done=0, busy=0, cfg_ready=1.
- States: S_OFF, S_ON, S_BLINK, S_BURST.
- cfg_ready = (state != S_BURST), combinational from state. busy = (state == S_BURST).
- Handshake: accepted on an edge where cfg_valid && cfg_ready. At that edge:
  - counter<=0.
  - half_period<=max(cfg_half_period,1).
  - state<=cfg_mode.
  - led_out<=1 for ON/BLINK/BURST, 0 for OFF.
  - burst_rem<=cfg_burst_cnt.
- Latency: led_out reflects the new mode in the cycle after the accepting edge.
- BURST with cfg_burst_cnt==0: state<=S_OFF, led_out<=0, done<=1 at the accepting edge.
- S_OFF/S_ON: counter held 0, tick=0, led_out constant.
- S_BLINK/S_BURST counting:
  - Each edge, if counter==half_period-1: counter<=0, led_out<=~led_out, tick<=1. Otherwise counter<=counter+1, tick<=0.
  - Each LED phase therefore lasts exactly half_period cycles.
- S_BURST, on a 1->0 toggle:
  - burst_rem<=burst_rem-1.
  - If burst_rem==1: state<=S_OFF and done<=1 on the same edge, tick also 1. led_out stays 0 afterwards.
- done is 1 for exactly one cycle, otherwise 0.
- Simultaneous handshake and terminal count (S_BLINK): configuration wins. No toggle, no tick, counter<=0.
- cfg_valid during S_BURST: ignored (cfg_ready=0). Requester must hold cfg_valid; it is accepted the cycle after burst end.
- Reset mid-burst: immediate abort to reset values; no done pulse.
- counter never exceeds half_period-1; no wrap beyond CNT_WIDTH.

Decomposition:
- Package led_blink_pkg:
  - mode_e enum (2-bit, encodings above).
  - state_e enum (S_OFF, S_ON, S_BLINK, S_BURST).
  - DEFAULT_HALF_PERIOD default constant.
- Sub-module tick_counter:
  - Ports: clk_in, rst, clear, enable, terminal (CNT_WIDTH), tc_pulse.
  - Programmable terminal-count counter.
- Top FSM instantiates one tick_counter.

Test Plan:
- Reset: hold rst=0 3 cycles, release -> led_out=0, tick=0, cfg_ready=1, busy=0, done=0.
- BLINK hp=3 (handshake at edge 0):
  - led_out=1 after edge 0, 0 after edge 3, 1 after edge 6.
  - tick high the cycle after edges 3, 6, 9.
- BURST hp=2, N=2:
  - led_out pattern after handshake: 1,1,0,0,1,1,0 then 0 forever.
  - done and last tick pulse together.
  - busy=1 and cfg_ready=0 throughout the burst.
- BURST N=0 -> done pulses one cycle after handshake, led_out=0, cfg_ready stays 1.
- Edge cases:
  - cfg_half_period=0 in BLINK -> LED toggles every cycle, tick constantly 1.
  - Handshake coinciding with terminal count -> no toggle that edge, counter restarts.
- Mid-operation requests:
  - rst=0 mid-burst -> outputs return to reset values next cycle, no done.
  - cfg_valid held during a burst -> accepted exactly one cycle after done.
